// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchronizer, per-channel
// stability counter, debounced level plus one-cycle press/release pulses.
module button_debouncer #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic               clk,
  input  logic               rst_btn,
  input  logic [NUM_BTN-1:0] pmod,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  // Buttons idle high, so the synchronizer resets to the released level.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pmod;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             stable_q;
      logic             stable_d;
      logic             press_q;
      logic             press_d;
      logic             release_q;
      logic             release_d;

      // Any sample agreeing with the stable level restarts qualification.
      always_comb begin
        cnt_d     = '0;
        stable_d  = stable_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q[gi] != stable_q) begin
          if (cnt_q == CNT_MAX) begin
            stable_d  = sync2_q[gi];
            press_d   = ~sync2_q[gi];
            release_d = sync2_q[gi];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
          cnt_q     <= '0;
          stable_q  <= 1'b1;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          stable_q  <= stable_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      assign btn_level[gi]   = stable_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: vector table, hand-written corner
// sequences and randomized stimulus against a sliding-window reference model.
module tb_button_debouncer;
  localparam int NB = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_btn;
  logic [NB-1:0] pmod;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  button_debouncer #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_btn(rst_btn), .pmod(pmod),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a change is accepted when the last D synchronized
  // samples all disagree with the accepted level.
  logic [NB-1:0] m_stable, m_press, m_release;
  logic [NB-1:0] samp[$];
  int press_cnt[NB];
  int rel_cnt[NB];

  typedef struct {
    logic [NB-1:0] pmod;
    int            hold;
    logic [NB-1:0] exp_level;
    logic [NB-1:0] exp_press;
    logic [NB-1:0] exp_release;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    for (int i = 0; i < D + 2; i++) samp.push_back('1);
    m_stable  = '1;
    m_press   = '0;
    m_release = '0;
  endtask

  task automatic model_edge(input logic [NB-1:0] p);
    int n;
    n = samp.size();
    m_press   = '0;
    m_release = '0;
    for (int c = 0; c < NB; c++) begin
      bit all_diff;
      all_diff = 1'b1;
      // samp[n-1] sits in sync1; the window starts at the value in sync2
      for (int k = 0; k < D; k++)
        if (samp[n-2-k][c] == m_stable[c]) all_diff = 1'b0;
      if (all_diff) begin
        if (m_stable[c]) m_press[c] = 1'b1;
        else m_release[c] = 1'b1;
        m_stable[c] = ~m_stable[c];
      end
    end
    samp.push_back(p);
    if (samp.size() > D + 4) void'(samp.pop_front());
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
    end
  endtask

  task automatic step(input logic [NB-1:0] p);
    pmod = p;
    @(posedge clk);
    if (!rst_btn) model_reset();
    else model_edge(p);
    #1;
    check("level", 32'(btn_level), 32'(m_stable));
    check("press", 32'(btn_press), 32'(m_press));
    check("release", 32'(btn_release), 32'(m_release));
    check("press_and_release", 32'(|(btn_press & btn_release)), 32'd0);
    for (int c = 0; c < NB; c++) begin
      press_cnt[c] += int'(btn_press[c]);
      rel_cnt[c]   += int'(btn_release[c]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, 32'(btn_level), 32'h3);
    check({tag, "_press"}, 32'(btn_press), 32'h0);
    check({tag, "_release"}, 32'(btn_release), 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    int first_edge;
    int ch_edge[NB];

    vecs[0] = '{2'b11, 8,  2'b11, 2'b00, 2'b00};
    vecs[1] = '{2'b10, 10, 2'b10, 2'b01, 2'b00};
    vecs[2] = '{2'b11, 10, 2'b11, 2'b00, 2'b01};
    vecs[3] = '{2'b01, 2,  2'b11, 2'b00, 2'b00};
    vecs[4] = '{2'b11, 8,  2'b11, 2'b00, 2'b00};
    vecs[5] = '{2'b00, 10, 2'b00, 2'b11, 2'b00};
    vecs[6] = '{2'b11, 10, 2'b11, 2'b00, 2'b11};

    // Asynchronous reset, checked before any clock edge
    rst_btn = 1'b1;
    pmod    = '1;
    #2 rst_btn = 1'b0;
    model_reset();
    #1 check_reset_outputs("async_reset");
    step(2'b00);
    step(2'b00);
    check_reset_outputs("held_reset");
    rst_btn = 1'b1;
    step(2'b11);
    step(2'b11);
    step(2'b11);
    $display("reset: level=%b press=%b release=%b", btn_level, btn_press, btn_release);

    for (int v = 0; v < 7; v++) begin
      clear_counts();
      for (int i = 0; i < vecs[v].hold; i++) step(vecs[v].pmod);
      check($sformatf("vec%0d_level", v), 32'(btn_level), 32'(vecs[v].exp_level));
      for (int c = 0; c < NB; c++) begin
        check($sformatf("vec%0d_press_cnt%0d", v, c), press_cnt[c], int'(vecs[v].exp_press[c]));
        check($sformatf("vec%0d_rel_cnt%0d", v, c), rel_cnt[c], int'(vecs[v].exp_release[c]));
      end
      $display("vec %0d: pmod=%b hold=%0d level=%b presses=%0d/%0d releases=%0d/%0d",
               v, vecs[v].pmod, vecs[v].hold, btn_level, press_cnt[0], press_cnt[1],
               rel_cnt[0], rel_cnt[1]);
    end

    // Clean press: level and pulse both appear on the 6th edge
    clear_counts();
    first_edge = -1;
    for (int e = 1; e <= 10; e++) begin
      step(2'b10);
      if (first_edge < 0 && btn_level[0] == 1'b0) begin
        first_edge = e;
        check("clean_press_pulse", 32'(btn_press), 32'h1);
      end
    end
    check("clean_press_edge", first_edge, 6);
    check("clean_press_cnt", press_cnt[0], 1);
    check("clean_press_ch1", press_cnt[1] + rel_cnt[1] + int'(!btn_level[1]), 0);
    $display("seq clean_press: level edge=%0d presses=%0d", first_edge, press_cnt[0]);

    // Release after press
    clear_counts();
    first_edge = -1;
    for (int e = 1; e <= 10; e++) begin
      step(2'b11);
      if (first_edge < 0 && btn_level[0] == 1'b1) begin
        first_edge = e;
        check("release_pulse", 32'(btn_release), 32'h1);
      end
    end
    check("release_edge", first_edge, 6);
    check("release_cnt", rel_cnt[0], 1);
    check("release_no_press", press_cnt[0], 0);
    $display("seq release: level edge=%0d releases=%0d", first_edge, rel_cnt[0]);

    // Bounce: low 3, high 1, then low held; final fall sampled on edge 5
    clear_counts();
    first_edge = -1;
    for (int e = 1; e <= 14; e++) begin
      step((e == 4) ? 2'b11 : 2'b10);
      if (first_edge < 0 && btn_level != 2'b11) first_edge = e;
    end
    check("bounce_edge_after_final_fall", first_edge - 4, 6);
    check("bounce_press_cnt", press_cnt[0], 1);
    $display("seq bounce: change %0d edges after final fall, presses=%0d", first_edge - 4, press_cnt[0]);
    for (int e = 0; e < 10; e++) step(2'b11);

    // Reset after two qualifying edges discards the partial count
    clear_counts();
    for (int e = 0; e < 4; e++) step(2'b00);
    rst_btn = 1'b0;
    model_reset();
    #1 check_reset_outputs("mid_reset");
    step(2'b00);
    step(2'b00);
    rst_btn = 1'b1;
    clear_counts();
    for (int c = 0; c < NB; c++) ch_edge[c] = -1;
    for (int e = 1; e <= 10; e++) begin
      step(2'b00);
      for (int c = 0; c < NB; c++)
        if (ch_edge[c] < 0 && btn_press[c]) ch_edge[c] = e;
    end
    check("post_reset_press_edge0", ch_edge[0], 6);
    check("post_reset_press_edge1", ch_edge[1], 6);
    check("post_reset_press_cnt0", press_cnt[0], 1);
    check("post_reset_press_cnt1", press_cnt[1], 1);
    $display("seq mid_reset: press edges=%0d/%0d", ch_edge[0], ch_edge[1]);

    // Reset while pressed forces the released level without a clock
    rst_btn = 1'b0;
    model_reset();
    #1 check_reset_outputs("pressed_reset");
    step(2'b00);
    rst_btn = 1'b1;
    clear_counts();
    for (int e = 0; e < 10; e++) step(2'b11);
    check("after_reset_no_pulses", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1], 0);
    $display("seq pressed_reset: level=%b", btn_level);

    // Randomized segments checked cycle by cycle against the model
    for (int t = 0; t < 60; t++) begin
      logic [NB-1:0] p;
      int hold;
      p    = NB'($urandom_range(0, 3));
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) step(p);
      $display("rand %0d: pmod=%b hold=%0d level=%b", t, p, hold, btn_level);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
